branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Fetch-side predictor for BLT/BEQ. Answers each fetched branch with a taken/not-taken guess,
//  which drives i_condition into the branch unit. Consumes the branch unit's commit-time report
//  (pred_condition/true_condition/pred_miss) to train 2-bit counters. Sequences clear/redirect on a miss.
// PARAMETERS
//  BHT_W        6            log2 number of 2-bit counters (64 entries)
//  PC_SHIFT     0            low PC bits dropped before indexing
//  FIFO_W       N_STATIONS_W log2 depth of in-flight branch queue (program order)
//  FLUSH_CYCLES 2            cycles 'flush' stays high after a miss (>=1)
//  GHR_W        4            global history width (used only with BP_GSHARE_EN)
// PORTS
//  clk            in  1        clock, rising edge
//  nrst           in  1        asynchronous active-low reset
//  q_valid        in  1        fetch presents an instruction for prediction
//  q_pc           in  DATA_W   instruction PC
//  q_opcode       in  INSTR_W  instruction opcode
//  q_ready        out 1        query accepted when q_valid & q_ready
//  q_taken        out 1        prediction for current query, combinational (-> i_condition)
//  commit_valid   in  1        ROB commits an instruction this cycle
//  commit_opcode  in  INSTR_W  committed opcode
//  pred_condition in  1        branch unit: prediction it recorded
//  true_condition in  1        branch unit: resolved outcome
//  pred_miss      in  1        branch unit: misprediction at commit
//  flush          out 1        registered; drives 'clear' of execution units/ROB
//  redirect_valid out 1        fetch must restart; held until redirect_ready
//  redirect_taken out 1        correct direction for redirect (true_condition; 1 for JMPR)
//  redirect_ready in  1        fetch accepts redirect
//  bp_err         out 1        sticky protocol error flag; cleared only by reset
// BEHAVIOUR
//  Reset (nrst=0, async): all counters=2'b01, GHR=0, queue empty.
//   State IDLE; flush=0, redirect_valid=0, redirect_taken=0, bp_err=0.
//  q_ready = (state==IDLE) & ~queue_full; q_taken=0 whenever q_ready=0.
//  Index idx = q_pc[PC_SHIFT+:BHT_W]. q_taken = cnt[idx][1] for BLT/BEQ, 1 for JMP/JMPR, 0 otherwise.
//  Accepted BLT/BEQ query pushes {idx,q_taken} into the queue; other opcodes push nothing.
//  Commit (IDLE, commit_valid, opcode BLT/BEQ): pop the queue head. Update cnt[head.idx] in the
//   following cycle (one-cycle latency): +1 if true_condition, -1 otherwise, saturating at 0 and 3.
//  Commit with an empty queue: set bp_err; no update. head.pred != pred_condition: set bp_err; update anyway.
//  Same cycle: push + pop both allowed. A full queue stays full for that cycle (q_ready=0 precedes pop).
//  Same cycle: a commit update and a query to the same idx. The query sees the old counter (no bypass).
//  pred_miss=1 in IDLE (BLT/BEQ or JMPR):
//   - capture redirect_taken;
//   - next cycle enter FLUSH with flush=1 and the queue emptied (younger branches discarded).
//   JMPR miss pops nothing. JMP/other commits leave the queue untouched.
//  FSM: IDLE -pred_miss-> FLUSH (FLUSH_CYCLES cycles, flush=1) -> REDIRECT (redirect_valid=1)
//   -redirect_ready-> IDLE. Redirect data stays stable while waiting.
//  commit_valid outside IDLE: ignored, sets bp_err.
//  nrst asserted mid-FLUSH/REDIRECT: immediate return to reset values.
// CONFIGURATION
//  BP_GSHARE_EN defined:
//   - idx = q_pc[PC_SHIFT+:BHT_W] ^ {{(BHT_W-GHR_W){1'b0}},ghr};
//   - ghr shifts in true_condition on every BLT/BEQ commit (non-speculative);
//   - the stored queue idx is used for the update.
//  Undefined: pure bimodal, no ghr register.
// STRUCTURE
//  fcpu_pkg additions:
//   - bp_state_t enum {BP_IDLE,BP_FLUSH,BP_REDIRECT};
//   - bp_entry_t struct {idx,pred};
//   - BP_CNT_INIT=2'b01.
//  Sub-module bp_counter_table: counter array with 1 read port (query) and 1 saturating update port.
//  Queue and FSM live in branch_predictor.
// TESTING
//  1 Reset, query BEQ pc=0x10 -> q_taken=0, q_ready=1. Two taken commits -> cnt=3; requery -> q_taken=1.
//  2 Fill queue with 4 BLT (FIFO_W=2) -> q_ready=0 on 5th. Commit one -> q_ready=1 the next cycle.
//  3 Commit BEQ pred_miss=1, true=1 -> flush=1 for 2 cycles, then redirect_valid=1, taken=1.
//    Hold redirect_ready=0 3 cycles -> signals stable. Then IDLE with queue empty.
//  4 Commit BLT with empty queue -> bp_err=1, counters unchanged.
//  5 JMPR commit with pred_miss=1 -> flush/redirect with redirect_taken=1; queue count unchanged before flush.
//  6 BP_GSHARE_EN, ghr=4'b1010 after 4 commits, query pc=0x03 -> counter index 0x09 read.

Source files
------------

// File: rtl/fcpu_pkg.sv
// fcpu_pkg: shared CPU definitions (datapath widths, opcodes) plus the
// branch-predictor additions: FSM state type, in-flight queue entry and
// counter reset value.
package fcpu_pkg;

  localparam int DATA_W       = 32;
  localparam int INSTR_W      = 4;
  localparam int N_STATIONS_W = 2;

  localparam logic [INSTR_W-1:0] OP_NOP  = 4'h0;
  localparam logic [INSTR_W-1:0] OP_ADD  = 4'h1;
  localparam logic [INSTR_W-1:0] OP_SUB  = 4'h2;
  localparam logic [INSTR_W-1:0] OP_LD   = 4'h4;
  localparam logic [INSTR_W-1:0] OP_ST   = 4'h5;
  localparam logic [INSTR_W-1:0] OP_BEQ  = 4'h8;
  localparam logic [INSTR_W-1:0] OP_BLT  = 4'h9;
  localparam logic [INSTR_W-1:0] OP_JMP  = 4'hA;
  localparam logic [INSTR_W-1:0] OP_JMPR = 4'hB;

  typedef enum logic [1:0] {
    BP_IDLE,
    BP_FLUSH,
    BP_REDIRECT
  } bp_state_t;

  localparam logic [1:0] BP_CNT_INIT = 2'b01;

  // Entry index field is sized for the largest supported table; the
  // predictor stores its BHT_W-bit index zero-extended.
  localparam int BP_IDX_MAX_W = 16;

  typedef struct packed {
    logic [BP_IDX_MAX_W-1:0] idx;
    logic                    pred;
  } bp_entry_t;

  function automatic logic bp_is_cond(input logic [INSTR_W-1:0] op);
    return (op == OP_BEQ) || (op == OP_BLT);
  endfunction

endpackage

// File: rtl/branch_predictor_counter_table.sv
// bp_counter_table: array of 2^BHT_W two-bit saturating counters.
//   clk, nrst   clock / asynchronous active-low reset (all counters -> BP_CNT_INIT)
//   rd_idx      query read index
//   rd_cnt      counter value at rd_idx (combinational, pre-update value)
//   upd_en      apply one saturating step this edge
//   upd_idx     counter to step
//   upd_taken   1: increment (sat at 3), 0: decrement (sat at 0)
module bp_counter_table
  import fcpu_pkg::*;
#(
  parameter int BHT_W = 6
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [BHT_W-1:0] rd_idx,
  output logic [1:0]       rd_cnt,
  input  logic             upd_en,
  input  logic [BHT_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int unsigned N_CNT = 1 << BHT_W;

  logic [1:0] cnt [N_CNT];

  assign rd_cnt = cnt[rd_idx];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned i = 0; i < N_CNT; i++) begin
        cnt[i] <= BP_CNT_INIT;
      end
    end else if (upd_en) begin
      if (upd_taken && (cnt[upd_idx] != 2'b11)) begin
        cnt[upd_idx] <= cnt[upd_idx] + 2'b01;
      end else if (!upd_taken && (cnt[upd_idx] != 2'b00)) begin
        cnt[upd_idx] <= cnt[upd_idx] - 2'b01;
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: fetch-side BLT/BEQ direction predictor with commit-time
// training and miss recovery sequencing (flush, then redirect handshake).
//   clk, nrst         clock / asynchronous active-low reset
//   q_valid/q_ready   prediction query handshake
//   q_pc, q_opcode    queried instruction
//   q_taken           combinational guess (0 whenever q_ready=0)
//   commit_*          ROB commit report; pred_condition/true_condition/pred_miss
//                     from the branch unit
//   flush             registered clear for execution units / ROB
//   redirect_valid/_ready/_taken  fetch restart handshake and direction
//   bp_err            sticky protocol error (commit on empty queue, prediction
//                     mismatch, commit outside IDLE)
// Build option: BP_GSHARE_EN -- XOR a global history register into the index.
module branch_predictor
  import fcpu_pkg::*;
#(
  parameter int BHT_W        = 6,
  parameter int PC_SHIFT     = 0,
  parameter int FIFO_W       = N_STATIONS_W,
  parameter int FLUSH_CYCLES = 2,
  parameter int GHR_W        = 4
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               q_valid,
  input  logic [DATA_W-1:0]  q_pc,
  input  logic [INSTR_W-1:0] q_opcode,
  output logic               q_ready,
  output logic               q_taken,
  input  logic               commit_valid,
  input  logic [INSTR_W-1:0] commit_opcode,
  input  logic               pred_condition,
  input  logic               true_condition,
  input  logic               pred_miss,
  output logic               flush,
  output logic               redirect_valid,
  output logic               redirect_taken,
  input  logic               redirect_ready,
  output logic               bp_err
);

  localparam int unsigned DEPTH = 1 << FIFO_W;
  localparam int          FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  bp_state_t state, state_next;

  logic [FC_W-1:0]   fcnt;
  bp_entry_t         q_mem [DEPTH];
  logic [FIFO_W-1:0] wr_ptr, rd_ptr;
  logic [FIFO_W:0]   count;

  logic [BHT_W-1:0]  q_idx, upd_idx;
  logic [1:0]        rd_cnt;
  logic              upd_en, upd_taken;

  logic              in_idle, q_empty, q_full, q_is_cond, q_is_jmp;
  logic              push, pop, cm_cond, cm_jmpr, miss, err_set;
  bp_entry_t         head, new_entry;

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] ghr;

  assign q_idx = q_pc[PC_SHIFT +: BHT_W] ^ BHT_W'(ghr);

  // Non-speculative history: only resolved conditional branches shift in.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ghr <= '0;
    end else if (cm_cond) begin
      ghr <= {ghr[GHR_W-2:0], true_condition};
    end
  end
`else
  logic [7:0] unused_ghr_w;

  assign q_idx        = q_pc[PC_SHIFT +: BHT_W];
  assign unused_ghr_w = 8'(GHR_W);
`endif

  bp_counter_table #(
    .BHT_W (BHT_W)
  ) u_table (
    .clk       (clk),
    .nrst      (nrst),
    .rd_idx    (q_idx),
    .rd_cnt    (rd_cnt),
    .upd_en    (upd_en),
    .upd_idx   (upd_idx),
    .upd_taken (upd_taken)
  );

  assign in_idle   = (state == BP_IDLE);
  assign q_empty   = (count == '0);
  assign q_full    = (count == (FIFO_W+1)'(DEPTH));
  assign q_is_cond = bp_is_cond(q_opcode);
  assign q_is_jmp  = (q_opcode == OP_JMP) || (q_opcode == OP_JMPR);

  // Fullness is judged before any same-cycle pop.
  assign q_ready   = in_idle & ~q_full;
  assign q_taken   = q_ready & ((q_is_cond & rd_cnt[1]) | q_is_jmp);
  assign push      = q_valid & q_ready & q_is_cond;
  assign new_entry = '{idx: BP_IDX_MAX_W'(q_idx), pred: q_taken};

  assign head      = q_mem[rd_ptr];
  assign cm_cond   = commit_valid & in_idle & bp_is_cond(commit_opcode);
  assign cm_jmpr   = commit_valid & in_idle & (commit_opcode == OP_JMPR);
  assign pop       = cm_cond & ~q_empty;
  assign miss      = pred_miss & (cm_cond | cm_jmpr);
  assign err_set   = (cm_cond & q_empty)
                   | (pop & (head.pred != pred_condition))
                   | (commit_valid & ~in_idle);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= BP_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      BP_IDLE:     if (miss) state_next = BP_FLUSH;
      BP_FLUSH:    if (fcnt == FC_W'(FLUSH_CYCLES - 1)) state_next = BP_REDIRECT;
      BP_REDIRECT: if (redirect_ready) state_next = BP_IDLE;
      default:     state_next = BP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fcnt           <= '0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_taken <= 1'b0;
      bp_err         <= 1'b0;
      upd_en         <= 1'b0;
      upd_idx        <= '0;
      upd_taken      <= 1'b0;
    end else begin
      fcnt           <= (state == BP_FLUSH) ? fcnt + FC_W'(1) : '0;
      // Registered copies of the next-state decode keep these glitch-free.
      flush          <= (state_next == BP_FLUSH);
      redirect_valid <= (state_next == BP_REDIRECT);
      if (miss) begin
        redirect_taken <= cm_jmpr | true_condition;
      end
      if (err_set) begin
        bp_err <= 1'b1;
      end
      // Training lands one cycle after the pop, so same-cycle queries see the old count.
      upd_en    <= pop;
      upd_idx   <= head.idx[BHT_W-1:0];
      upd_taken <= true_condition;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (miss) begin
      // Everything younger than the mispredicted branch is discarded.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_W'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_W'(1);
      count <= count + (FIFO_W+1)'(push) - (FIFO_W+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_mem[wr_ptr] <= new_entry;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{q_pc, head.idx};

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
  import fcpu_pkg::*;

  localparam int BHT_W        = 6;
  localparam int PC_SHIFT     = 0;
  localparam int FIFO_W       = 2;
  localparam int FLUSH_CYCLES = 2;
  localparam int GHR_W        = 4;
  localparam int NCNT         = 1 << BHT_W;
  localparam int DEPTH        = 1 << FIFO_W;

  logic               clk = 1'b0;
  logic               nrst;
  logic               q_valid;
  logic [DATA_W-1:0]  q_pc;
  logic [INSTR_W-1:0] q_opcode;
  logic               q_ready, q_taken;
  logic               commit_valid;
  logic [INSTR_W-1:0] commit_opcode;
  logic               pred_condition, true_condition, pred_miss;
  logic               flush, redirect_valid, redirect_taken, redirect_ready, bp_err;

  always #5 clk = ~clk;

  branch_predictor #(
    .BHT_W        (BHT_W),
    .PC_SHIFT     (PC_SHIFT),
    .FIFO_W       (FIFO_W),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .GHR_W        (GHR_W)
  ) dut (
    .clk            (clk),
    .nrst           (nrst),
    .q_valid        (q_valid),
    .q_pc           (q_pc),
    .q_opcode       (q_opcode),
    .q_ready        (q_ready),
    .q_taken        (q_taken),
    .commit_valid   (commit_valid),
    .commit_opcode  (commit_opcode),
    .pred_condition (pred_condition),
    .true_condition (true_condition),
    .pred_miss      (pred_miss),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_taken (redirect_taken),
    .redirect_ready (redirect_ready),
    .bp_err         (bp_err)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    bit rdy, tkn, fl, rv, rt, err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(string name, logic act, bit req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("q_ready",        q_ready,        e.rdy);
      chk("q_taken",        q_taken,        e.tkn);
      chk("flush",          flush,          e.fl);
      chk("redirect_valid", redirect_valid, e.rv);
      chk("redirect_taken", redirect_taken, e.rt);
      chk("bp_err",         bp_err,         e.err);
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int idx;
    bit pred;
  } ent_t;

  int   m_cnt[NCNT];
  ent_t m_q[$];
  int   m_phase;   // 0 idle, 1 flushing, 2 waiting for redirect acceptance
  int   m_fleft;
  int   m_ghr;
  bit   m_rt, m_err;
  bit   pend_en, pend_t;
  int   pend_idx;

  function automatic void model_reset();
    for (int i = 0; i < NCNT; i++) m_cnt[i] = 1;
    m_q.delete();
    m_phase = 0; m_fleft = 0; m_ghr = 0;
    m_rt = 0; m_err = 0; pend_en = 0; pend_t = 0; pend_idx = 0;
  endfunction

  function automatic bit is_br(logic [INSTR_W-1:0] op);
    return (op == OP_BEQ) || (op == OP_BLT);
  endfunction

  function automatic int q_index(logic [DATA_W-1:0] pc);
    int b;
    b = int'((pc >> PC_SHIFT) & (NCNT - 1));
`ifdef BP_GSHARE_EN
    b = b ^ m_ghr;
`endif
    return b;
  endfunction

  function automatic exp_t model_outputs();
    exp_t e;
    int   idx;
    idx   = q_index(q_pc);
    e.rdy = (m_phase == 0) && (m_q.size() < DEPTH);
    e.tkn = e.rdy && (is_br(q_opcode) ? (m_cnt[idx] >= 2)
                                      : ((q_opcode == OP_JMP) || (q_opcode == OP_JMPR)));
    e.fl  = (m_phase == 1);
    e.rv  = (m_phase == 2);
    e.rt  = m_rt;
    e.err = m_err;
    return e;
  endfunction

  function automatic void model_step();
    bit   rdy, acc, tk, miss;
    int   idx;
    ent_t h;
    rdy  = (m_phase == 0) && (m_q.size() < DEPTH);
    acc  = q_valid && rdy && is_br(q_opcode);
    idx  = q_index(q_pc);
    tk   = (m_cnt[idx] >= 2);
    miss = 0;
    if (pend_en) begin
      if (pend_t) m_cnt[pend_idx] = (m_cnt[pend_idx] < 3) ? m_cnt[pend_idx] + 1 : 3;
      else        m_cnt[pend_idx] = (m_cnt[pend_idx] > 0) ? m_cnt[pend_idx] - 1 : 0;
      pend_en = 0;
    end
    if (m_phase == 0) begin
      if (commit_valid) begin
        if (is_br(commit_opcode)) begin
          if (m_q.size() == 0) m_err = 1;
          else begin
            h = m_q.pop_front();
            if (h.pred != pred_condition) m_err = 1;
            pend_en = 1; pend_idx = h.idx; pend_t = true_condition;
          end
          m_ghr = ((m_ghr << 1) | int'(true_condition)) & ((1 << GHR_W) - 1);
        end
        miss = pred_miss && (is_br(commit_opcode) || (commit_opcode == OP_JMPR));
      end
      if (acc) m_q.push_back('{idx, tk});
      if (miss) begin
        m_rt = (commit_opcode == OP_JMPR) ? 1'b1 : true_condition;
        m_q.delete();
        m_phase = 1;
        m_fleft = FLUSH_CYCLES;
      end
    end else if (m_phase == 1) begin
      if (commit_valid) m_err = 1;
      m_fleft--;
      if (m_fleft == 0) m_phase = 2;
    end else begin
      if (commit_valid) m_err = 1;
      if (redirect_ready) m_phase = 0;
    end
  endfunction

  // ---------------- stimulus ----------------
  task automatic drive(bit qv, logic [DATA_W-1:0] pc, logic [INSTR_W-1:0] qop,
                       bit cv, logic [INSTR_W-1:0] cop, bit pcnd, bit tc, bit pm, bit rr);
    q_valid = qv; q_pc = pc; q_opcode = qop;
    commit_valid = cv; commit_opcode = cop;
    pred_condition = pcnd; true_condition = tc; pred_miss = pm;
    redirect_ready = rr;
    if (!nrst) model_reset();
    exp_q.push_back(model_outputs());
    @(posedge clk);
    if (nrst) model_step();
    #1;
  endtask

  task automatic idle(bit rr);
    drive(0, '0, OP_NOP, 0, OP_NOP, 0, 0, 0, rr);
  endtask

  task automatic query(logic [DATA_W-1:0] pc, logic [INSTR_W-1:0] op);
    drive(1, pc, op, 0, OP_NOP, 0, 0, 0, 0);
  endtask

  task automatic commit_head(logic [INSTR_W-1:0] op, bit tc, bit pm);
    bit p;
    p = (m_q.size() > 0) ? m_q[0].pred : 1'b0;
    drive(0, '0, OP_NOP, 1, op, p, tc, pm, 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && m_phase != 0; i++) idle(1);
    checks++;
    if (m_phase != 0) begin
      errors++;
      $display("FAIL wait_idle: model phase %0d required 0 within budget", m_phase);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && m_q.size() > 0; i++) commit_head(OP_BLT, m_q[0].pred, 0);
  endtask

  task automatic rand_cycle(bit allow_bad);
    logic [INSTR_W-1:0] qops [6];
    bit                 qv, cv, pcnd, tc, pm, rr;
    logic [DATA_W-1:0]  pc;
    logic [INSTR_W-1:0] qop, cop;
    int                 r;
    qops = '{OP_BEQ, OP_BLT, OP_BEQ, OP_JMP, OP_JMPR, OP_ADD};
    qv   = ($urandom_range(0, 3) != 0);
    pc   = DATA_W'($urandom_range(0, 127));
    qop  = qops[$urandom_range(0, 5)];
    cv = 0; cop = OP_NOP; pcnd = 0; pm = 0;
    tc = 1'($urandom_range(0, 1));
    rr = ($urandom_range(0, 2) == 0);
    r  = $urandom_range(0, 9);
    if (m_phase == 0) begin
      if (m_q.size() > 0 && r < 5) begin
        cv   = 1;
        cop  = (r < 3) ? OP_BEQ : OP_BLT;
        pcnd = m_q[0].pred;
        tc   = ($urandom_range(0, 2) == 0) ? ~pcnd : pcnd;
        pm   = (pcnd != tc);
      end else if (r == 5) begin
        cv = 1; cop = OP_JMPR; pm = 1'($urandom_range(0, 1));
      end else if (r == 6) begin
        cv = 1; cop = OP_JMP;
      end else if (allow_bad && r == 7) begin
        cv = 1; cop = OP_BLT; pcnd = 1'($urandom_range(0, 1));
      end
    end else if (allow_bad && r == 8) begin
      cv = 1; cop = OP_BEQ;
    end
    drive(qv, pc, qop, cv, cop, pcnd, tc, pm, rr);
  endtask

  initial begin
    nrst = 0;
    q_valid = 0; q_pc = '0; q_opcode = OP_NOP;
    commit_valid = 0; commit_opcode = OP_NOP;
    pred_condition = 0; true_condition = 0; pred_miss = 0; redirect_ready = 0;
    model_reset();
    @(posedge clk); #1;

    // reset state
    idle(0); idle(0); idle(0);
    nrst = 1;
    idle(0);

    // training: two taken commits raise counter to 3
    query(32'h10, OP_BEQ);
    query(32'h10, OP_BEQ);
    commit_head(OP_BEQ, 1, 0);
    commit_head(OP_BEQ, 1, 0);
    idle(0);
    query(32'h10, OP_BEQ);
    commit_head(OP_BEQ, 1, 0);
    idle(0);

    // queue full, then one commit frees a slot
    for (int i = 0; i < 4; i++) query(DATA_W'(32'h20 + i), OP_BLT);
    drive(1, 32'h24, OP_BLT, 1, OP_BLT, m_q[0].pred, 0, 0, 0);
    query(32'h24, OP_BLT);
    drain();
    idle(0);

    // conditional-branch miss: flush, held redirect, return to idle empty
    query(32'h30, OP_BEQ);
    query(32'h31, OP_BEQ);
    query(32'h32, OP_BLT);
    commit_head(OP_BEQ, 1, 1);
    for (int i = 0; i < 5; i++) idle(0);
    idle(1);
    query(32'h33, OP_BEQ);
    commit_head(OP_BEQ, 0, 0);

    // JMPR miss: queue untouched until flush, redirect_taken=1
    query(32'h40, OP_BLT);
    query(32'h41, OP_BLT);
    drive(1, 32'h42, OP_JMP, 1, OP_JMPR, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) idle(0);
    idle(1);
    idle(0);

    // randomized, protocol-legal traffic
    for (int i = 0; i < 300; i++) rand_cycle(0);
    wait_idle();
    drain();
    idle(0);

    // commit with empty queue sets bp_err
    drive(0, '0, OP_NOP, 1, OP_BLT, 0, 1, 0, 0);
    idle(0);
    query(32'h10, OP_BEQ);

    // reset asserted mid-flush
    commit_head(OP_BEQ, 0, 1);
    idle(0);
    nrst = 0;
    idle(0);
    idle(0);
    nrst = 1;
    idle(0);

`ifdef BP_GSHARE_EN
    // history 1,0,1,0 -> ghr=1010; pc 0x03 indexes counter 0x09
    for (int i = 0; i < 4; i++) query(DATA_W'(i), OP_BEQ);
    commit_head(OP_BEQ, 1, 0);
    commit_head(OP_BEQ, 0, 0);
    commit_head(OP_BEQ, 1, 0);
    commit_head(OP_BEQ, 0, 0);
    idle(0);
    query(32'h03, OP_BEQ);
    commit_head(OP_BEQ, 1, 0);
    idle(0);
`endif

    // randomized traffic including protocol violations
    for (int i = 0; i < 200; i++) rand_cycle(1);
    wait_idle();
    idle(0);

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
